res_display: RTL and testbench
==============================

Name: res_display

Overview:
- Downstream consumer of the execute stage's signed result and carry outputs.
- Converts the signed result to sign plus three BCD digits using a sequential double-dabble engine.
- Drives the board's 4-digit multiplexed 7-segment display (anodes and segments active-low) and a carry LED.
- Display registers update atomically, so the display never shows a partially converted value.

Parameters:
- SIZE_OPERANDOS, 9, width of the signed result input; magnitude range 0..2^(SIZE_OPERANDOS-1).
- REFRESH_DIV, 100000, clock cycles each digit stays active; minimum legal value 2.

Ports:
- i_clock  input  1  system clock, all logic on the rising edge.
- i_reset_n  input  1  reset, asynchronous assert, active-low.
- i_res  input  SIZE_OPERANDOS  signed result from the execute stage (two's complement).
- i_carry  input  1  carry flag from the execute stage.
- o_seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- o_an  output  4  digit anodes, active-low; an[0] is the rightmost digit.
- o_dp  output  1  decimal point, active-low; constant 1 (off).
- o_carry_led  output  1  displayed carry, active-high.
- o_busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset: clock and reset ports named i_clock / i_reset_n. One clock; reset is asynchronous and active-low.
- Reset values: o_an=4'b1111, o_seg=7'b1111111, o_dp=1, o_carry_led=0, o_busy=0.
- Reset values (internal): captured value 0, captured carry 0, displayed digits 0/0/0, sign positive, mux counter 0, digit index 0, FSM IDLE.
- Reset mid-conversion aborts the conversion; the display returns to its reset state.
- Change detect: in IDLE, if {i_res,i_carry} differs from the captured pair, the FSM latches the pair and goes to LOAD on the next edge.
- Inputs are not sampled in any state other than IDLE.
- LOAD:
  - sign = i_res MSB; magnitude = |i_res| as SIZE_OPERANDOS-bit unsigned.
  - -256 must yield 256; no overflow.
  - BCD shift register cleared; bit counter = SIZE_OPERANDOS; o_busy=1.
- SHIFT:
  - One cycle per magnitude bit.
  - In each cycle, every BCD nibble >=5 gets +3, then {bcd,mag} shifts left by 1.
  - Exactly SIZE_OPERANDOS cycles, then DONE.
- DONE:
  - Display digits, sign and o_carry_led update together in one cycle; o_busy=0; next state IDLE.
  - Latency from the edge that captures a new pair to updated display registers: SIZE_OPERANDOS+2 cycles (11 at default).
- Input changes during a conversion are ignored. On return to IDLE the current input is compared against the captured pair, so the final stable value is always displayed, after at most two conversions.
- Mux:
  - Counter runs 0..REFRESH_DIV-1; on wrap, the digit index increments 0->1->2->3->0.
  - Exactly one anode is low at any time after reset.
  - o_an and o_seg are registered and change in the same cycle.
- Digit map:
  - Index 0 = units, 1 = tens, 2 = hundreds.
  - Index 3 = sign: '-' (7'b0111111) if negative, blank (7'b1111111) otherwise.
  - Zero is displayed as positive.
- Encoding: standard hex-free 0-9 patterns (0=7'b1000000, 1=7'b1111001, ..., 9=7'b0010000). BCD values >9 cannot occur and map to blank.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Hundreds digit blank when it is 0.
  - Tens digit blank when both hundreds and tens are 0.
  - Units digit always shown.
  - The sign stays on digit 3.
- Undefined: all three numeric digits always shown, including leading zeros.
- Conversion timing is identical in both builds.

Test Plan:
- Reset: assert i_reset_n=0 mid-mux -> o_an=1111, o_seg=1111111, o_carry_led=0 immediately (asynchronous); after release, first anode pattern is 1110.
- Positive value: i_res=123, i_carry=1, REFRESH_DIV=4 -> o_busy high for the conversion, update 11 cycles after capture. Cycling anodes then show 3,2,1 and blank sign; o_carry_led=1.
- Boundary: i_res=-256 -> digits 2,5,6 and sign '-'. Then i_res=255 -> 2,5,5 with blank sign. Then i_res=0 -> 0,0,0 with blank sign (with LEADING_ZERO_BLANK_EN: units 0, tens and hundreds blank).
- Mid-conversion change: i_res=7, then i_res=-42 three cycles later -> display first shows 7, then -042. No intermediate or mixed digits ever appear on o_seg.
- Carry-only change: i_res held at 50, i_carry 0->1 -> new conversion runs; digits unchanged, o_carry_led=1 after 11 cycles.
- No change: inputs held constant for 1000 cycles after a conversion -> o_busy stays 0; anodes rotate every REFRESH_DIV cycles.

Source files
------------

// File: rtl/res_display.sv
// -----------------------------------------------------------------------------
// res_display
//   Shows the execute stage's signed result on a 4-digit multiplexed 7-segment
//   display: digit 3 carries the sign, digits 2..0 the hundreds/tens/units of
//   the magnitude. A sequential double-dabble engine converts each new
//   {result, carry} pair. The display digits, sign and carry LED are loaded
//   together in one cycle, so a half-converted value is never shown.
//
// Parameters
//   SIZE_OPERANDOS : width of the two's complement result (magnitude up to
//                    2**(SIZE_OPERANDOS-1), three BCD digits)
//   REFRESH_DIV    : clock cycles each digit stays lit (>= 2)
//
// Ports
//   i_clock     : system clock, rising edge
//   i_reset_n   : asynchronous active-low reset
//   i_res       : signed result from the execute stage
//   i_carry     : carry flag from the execute stage
//   o_seg       : segments {g,f,e,d,c,b,a}, active-low
//   o_an        : digit anodes, active-low, o_an[0] = rightmost digit
//   o_dp        : decimal point, active-low, always off
//   o_carry_led : displayed carry, active-high
//   o_busy      : high while a conversion is running
//
// Build option
//   LEADING_ZERO_BLANK_EN : blank leading zeros of hundreds and tens
// -----------------------------------------------------------------------------
module res_display #(
  parameter int SIZE_OPERANDOS = 9,
  parameter int REFRESH_DIV    = 100000
) (
  input  logic                             i_clock,
  input  logic                             i_reset_n,
  input  logic signed [SIZE_OPERANDOS-1:0] i_res,
  input  logic                             i_carry,
  output logic [6:0]                       o_seg,
  output logic [3:0]                       o_an,
  output logic                             o_dp,
  output logic                             o_carry_led,
  output logic                             o_busy
);

  localparam int N     = SIZE_OPERANDOS;
  localparam int BCD_W = 12;
  localparam int CNT_W = $clog2(N + 1);
  localparam int MUX_W = $clog2(REFRESH_DIV);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t             state, state_next;
  logic [N-1:0]       cap_res;
  logic               cap_carry;
  logic               conv_neg;
  logic [N-1:0]       mag;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W+N-1:0] shifted;
  logic [CNT_W-1:0]   bit_cnt;
  logic [3:0]         dig_units, dig_tens, dig_hund;
  logic               disp_neg;
  logic [MUX_W-1:0]   mux_cnt;
  logic [1:0]         dig_idx;
  logic [6:0]         seg_sel;
  logic               changed;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'b1000000;
      4'd1:    seg_enc = 7'b1111001;
      4'd2:    seg_enc = 7'b0100100;
      4'd3:    seg_enc = 7'b0110000;
      4'd4:    seg_enc = 7'b0011001;
      4'd5:    seg_enc = 7'b0010010;
      4'd6:    seg_enc = 7'b0000010;
      4'd7:    seg_enc = 7'b1111000;
      4'd8:    seg_enc = 7'b0000000;
      4'd9:    seg_enc = 7'b0010000;
      default: seg_enc = SEG_BLANK;
    endcase
  endfunction

  assign o_dp    = 1'b1;
  assign o_busy  = (state == LOAD) || (state == SHIFT);
  assign changed = ({i_res, i_carry} != {cap_res, cap_carry});

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (changed) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (bit_cnt == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Double-dabble step: correct every nibble >= 5, then shift {bcd,mag} left.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    shifted = {bcd_adj, mag} << 1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      cap_res     <= '0;
      cap_carry   <= 1'b0;
      conv_neg    <= 1'b0;
      mag         <= '0;
      bcd         <= '0;
      bit_cnt     <= '0;
      dig_units   <= 4'd0;
      dig_tens    <= 4'd0;
      dig_hund    <= 4'd0;
      disp_neg    <= 1'b0;
      o_carry_led <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          // Inputs are only looked at here; changes during a conversion are
          // picked up when the FSM returns to IDLE.
          if (changed) begin
            cap_res   <= i_res;
            cap_carry <= i_carry;
          end
        end
        LOAD: begin
          // Unsigned N-bit negation: the most negative value maps to
          // 2**(N-1), which still fits.
          conv_neg <= cap_res[N-1];
          mag      <= cap_res[N-1] ? (~cap_res + N'(1)) : cap_res;
          bcd      <= '0;
          bit_cnt  <= CNT_W'(N);
        end
        SHIFT: begin
          bcd     <= shifted[BCD_W+N-1:N];
          mag     <= shifted[N-1:0];
          bit_cnt <= bit_cnt - CNT_W'(1);
        end
        DONE: begin
          dig_units   <= bcd[3:0];
          dig_tens    <= bcd[7:4];
          dig_hund    <= bcd[11:8];
          disp_neg    <= conv_neg && (bcd != '0);
          o_carry_led <= cap_carry;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Display multiplexing
  // ---------------------------------------------------------------------------
  always_comb begin
    seg_sel = SEG_BLANK;
    case (dig_idx)
      2'd0: seg_sel = seg_enc(dig_units);
`ifdef LEADING_ZERO_BLANK_EN
      2'd1: seg_sel = (dig_hund == 4'd0 && dig_tens == 4'd0) ? SEG_BLANK
                                                             : seg_enc(dig_tens);
      2'd2: seg_sel = (dig_hund == 4'd0) ? SEG_BLANK : seg_enc(dig_hund);
`else
      2'd1: seg_sel = seg_enc(dig_tens);
      2'd2: seg_sel = seg_enc(dig_hund);
`endif
      2'd3: seg_sel = disp_neg ? SEG_MINUS : SEG_BLANK;
      default: seg_sel = SEG_BLANK;
    endcase
  end

  // Anodes and segments are both registered from the same digit index so
  // they always change on the same edge.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mux_cnt <= '0;
      dig_idx <= 2'd0;
      o_an    <= 4'b1111;
      o_seg   <= SEG_BLANK;
    end else begin
      if (mux_cnt == MUX_W'(REFRESH_DIV - 1)) begin
        mux_cnt <= '0;
        dig_idx <= dig_idx + 2'd1;
      end else begin
        mux_cnt <= mux_cnt + MUX_W'(1);
      end
      o_an  <= ~(4'b0001 << dig_idx);
      o_seg <= seg_sel;
    end
  end

endmodule

// File: tb/tb_res_display.sv
// -----------------------------------------------------------------------------
// tb_res_display
//   Scoreboard bench for res_display (REFRESH_DIV = 4). The stimulus process
//   pushes the expected display (four segment patterns plus carry) for every
//   conversion it triggers; the monitor pops an entry each time a conversion
//   finishes and checks every multiplexed digit, the carry LED, the busy
//   length and the anode rotation on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_res_display;

  localparam int N   = 9;
  localparam int DIV = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [N-1:0] res;
  logic               carry;
  logic [6:0]         seg;
  logic [3:0]         an;
  logic               dp;
  logic               carry_led;
  logic               busy;

  res_display #(.SIZE_OPERANDOS(N), .REFRESH_DIV(DIV)) dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_res      (res),
    .i_carry    (carry),
    .o_seg      (seg),
    .o_an       (an),
    .o_dp       (dp),
    .o_carry_led(carry_led),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][6:0] seg;
    logic            carry;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = 7'b1000000;
      1: pat = 7'b1111001;
      2: pat = 7'b0100100;
      3: pat = 7'b0110000;
      4: pat = 7'b0011001;
      5: pat = 7'b0010010;
      6: pat = 7'b0000010;
      7: pat = 7'b1111000;
      8: pat = 7'b0000000;
      9: pat = 7'b0010000;
      default: pat = 7'b1111111;
    endcase
  endfunction

  function automatic exp_t make_exp(input bit neg, input int h, input int t,
                                    input int u, input bit c);
    exp_t e;
    e.seg[3] = neg ? 7'b0111111 : 7'b1111111;
    e.seg[0] = pat(u);
`ifdef LEADING_ZERO_BLANK_EN
    e.seg[1] = (h == 0 && t == 0) ? 7'b1111111 : pat(t);
    e.seg[2] = (h == 0) ? 7'b1111111 : pat(h);
`else
    e.seg[1] = pat(t);
    e.seg[2] = pat(h);
`endif
    e.carry = c;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  exp_t       cur;
  exp_t       pending;
  int         sw_cnt;
  int         busy_len;
  logic       busy_prev;
  int         run_len;
  logic [3:0] prev_an;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur       = make_exp(0, 0, 0, 0, 0);
      sw_cnt    = 0;
      busy_len  = 0;
      busy_prev = 1'b0;
      run_len   = 0;
      prev_an   = 4'b1111;
    end else begin
      // Carry LED is loaded on the edge after DONE, the segment register one
      // edge later.
      if (sw_cnt > 0) begin
        sw_cnt--;
        if (sw_cnt == 1) cur.carry = pending.carry;
        if (sw_cnt == 0) cur.seg   = pending.seg;
      end

      check("carry_led", carry_led, cur.carry);
      check("dp", dp, 1'b1);

      case (an)
        4'b1110: check("seg_units",    seg, cur.seg[0]);
        4'b1101: check("seg_tens",     seg, cur.seg[1]);
        4'b1011: check("seg_hundreds", seg, cur.seg[2]);
        4'b0111: check("seg_sign",     seg, cur.seg[3]);
        default: check("an_onehot",    an, 4'b1110);
      endcase

      if (an != prev_an) begin
        if (prev_an != 4'b1111) begin
          check("an_run_len", run_len, DIV);
          check("an_order", an, {prev_an[2:0], prev_an[3]});
        end
        run_len = 1;
        prev_an = an;
      end else begin
        run_len++;
        if (run_len == DIV + 1) check("an_stuck", run_len, DIV);
      end

      if (busy) busy_len++;
      if (busy_prev && !busy) begin
        check("busy_len", busy_len, N + 1);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard: conversion finished, no expected entry queued");
        end else begin
          pending = exp_q.pop_front();
          sw_cnt  = 2;
        end
        busy_len = 0;
      end
      busy_prev = busy;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply(input logic [N-1:0] r, input logic c, input exp_t e);
    @(negedge clk);
    exp_q.push_back(e);
    res   = r;
    carry = c;
  endtask

  // Cycles from driving a carry 0->1 change until the LED shows it:
  // capture edge + N+2 cycles -> 12th edge after the drive at N=9.
  task automatic check_latency(input string name);
    int k;
    k = 0;
    while (k < 40 && carry_led !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    check(name, k, N + 3);
  endtask

  initial begin
    bit busy_seen;
    rst_n = 1'b0;
    res   = '0;
    carry = 1'b0;
    settle(3);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check("an_after_reset", an, 4'b1110);
    settle(20);

    // Positive value with carry
    apply(9'd123, 1'b1, make_exp(0, 1, 2, 3, 1));
    check_latency("latency_123");
    settle(30);

    // Boundaries
    apply(9'h100, 1'b0, make_exp(1, 2, 5, 6, 0));   // -256
    settle(40);
    apply(9'd255, 1'b0, make_exp(0, 2, 5, 5, 0));
    settle(40);
    apply(9'd0, 1'b0, make_exp(0, 0, 0, 0, 0));
    settle(40);

    // Change in the middle of a conversion: 7 first, then -42
    apply(9'd7, 1'b0, make_exp(0, 0, 0, 7, 0));
    settle(3);
    exp_q.push_back(make_exp(1, 0, 4, 2, 0));
    res = 9'h1D6;                                    // -42
    settle(60);

    // Carry-only change
    apply(9'd50, 1'b0, make_exp(0, 0, 5, 0, 0));
    settle(40);
    apply(9'd50, 1'b1, make_exp(0, 0, 5, 0, 1));
    check_latency("latency_carry_only");
    settle(30);

    // Stable inputs: no conversion may start
    busy_seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    check("busy_idle_1000", busy_seen, 1'b0);

    // Reset in the middle of a conversion
    @(negedge clk);
    res = 9'd99;
    settle(4);
    check("busy_before_reset", busy, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'b1111111);
    check("rst_carry_led", carry_led, 1'b0);
    check("rst_busy", busy, 1'b0);
    res   = '0;
    carry = 1'b0;
    settle(3);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check("an_after_rst2", an, 4'b1110);
    settle(30);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
